// File: rtl/tlcd_panel_controller.sv
// tlcd_panel_controller: HD44780-class text LCD sequencer with an
// on-chip character buffer, glyph RAM and dirty-row refresh.
module tlcd_panel_controller #(
  parameter int ROWS         = 2,
  parameter int COLS         = 16,
  parameter int NUM_GLYPHS   = 5,
  parameter int PWR_WAIT_CYC = 15000,
  parameter int SETUP_CYC    = 2,
  parameter int E_PULSE_CYC  = 4,
  parameter int CMD_WAIT_CYC = 40,
  parameter int CLR_WAIT_CYC = 1640
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       WR_EN,
  input  logic [1:0] WR_ROW,
  input  logic [4:0] WR_COL,
  input  logic [7:0] WR_CHAR,
  input  logic       GLYPH_WE,
  input  logic [2:0] GLYPH_IDX,
  input  logic [2:0] GLYPH_ROW,
  input  logic [4:0] GLYPH_BITS,
  output logic       READY,
  output logic       BUSY,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic [7:0] TLCD_DATA
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS);
  localparam int M1 = (PWR_WAIT_CYC > CLR_WAIT_CYC) ?
                      PWR_WAIT_CYC : CLR_WAIT_CYC;
  localparam int M2 = (CMD_WAIT_CYC > E_PULSE_CYC) ?
                      CMD_WAIT_CYC : E_PULSE_CYC;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int MAXC = (M3 > SETUP_CYC) ? M3 : SETUP_CYC;
  localparam int TW = $clog2(MAXC + 1);

  localparam logic [TW-1:0] PWR_LIM = TW'(PWR_WAIT_CYC - 1);
  localparam logic [TW-1:0] SET_LIM = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PUL_LIM = TW'(E_PULSE_CYC - 1);
  localparam logic [TW-1:0] CMD_LIM = TW'(CMD_WAIT_CYC - 1);
  localparam logic [TW-1:0] CLR_LIM = TW'(CLR_WAIT_CYC - 1);
  localparam logic [6:0] CG_LAST   = 7'(8 * NUM_GLYPHS);
  localparam logic [6:0] DRAW_LAST = 7'(COLS);
  localparam logic [7:0] GMASK =
    8'((32'd1 << NUM_GLYPHS) - 32'd1);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_CG, S_IDLE, S_DRAW
  } state_t;

  typedef enum logic [1:0] {
    PH_OFF, PH_SET, PH_PUL, PH_GAP
  } phase_t;

  state_t state_q, state_d;
  phase_t ph_q;

  logic [TW-1:0] cnt_q;
  logic [6:0]    idx_q, idx_d;
  logic [7:0]    data_q, nxt_byte;
  logic          rs_q, nxt_rs;
  logic          ready_q;
  logic          ld, last, clr, byte_done;

  logic [RW-1:0] cur_q, row_d, sel_row, wr_r;
  logic [CW-1:0] col_d, wr_c;
  logic [5:0]    gk;
  logic [1:0]    rb;
  logic          wr_ok, gw_ok;

  logic [ROWS-1:0] row_dirty_q, row_dirty_d;
  logic [7:0]      glyph_dirty_q, glyph_dirty_d;

  logic [7:0] buf_q   [ROWS][COLS];
  logic [4:0] glyph_q [8][8];

  always_comb begin
    wr_r  = WR_ROW[RW-1:0];
    wr_c  = WR_COL[CW-1:0];
    wr_ok = WR_EN && (32'(WR_ROW) < ROWS) &&
            (32'(WR_COL) < COLS);
    gw_ok = GLYPH_WE && (32'(GLYPH_IDX) < NUM_GLYPHS);
  end

  always_comb begin
    sel_row = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (row_dirty_q[i]) sel_row = RW'(i);
  end

  always_comb begin
    last = 1'b0;
    unique case (state_q)
      S_INIT:  last = (idx_q == 7'd3);
      S_CG:    last = (idx_q == CG_LAST);
      S_DRAW:  last = (idx_q == DRAW_LAST);
      default: last = 1'b0;
    endcase
  end

  // Clear-display needs the long settle gap.
  always_comb begin
    clr = !rs_q && (data_q == 8'h01);
    byte_done = (ph_q == PH_GAP) &&
                (cnt_q == (clr ? CLR_LIM : CMD_LIM));
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= S_PWR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld = 1'b0;
    unique case (state_q)
      S_PWR:
        if (cnt_q == PWR_LIM) begin
          state_d = S_INIT;
          ld = 1'b1;
        end
      S_INIT:
        if (byte_done) begin
          if (!last) begin
            ld = 1'b1;
          end else if (NUM_GLYPHS > 0) begin
            state_d = S_CG;
            ld = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      S_CG, S_DRAW:
        if (byte_done) begin
          if (!last) ld = 1'b1;
          else       state_d = S_IDLE;
        end
      S_IDLE:
        if (|glyph_dirty_q) begin
          state_d = S_CG;
          ld = 1'b1;
        end else if (|row_dirty_q) begin
          state_d = S_DRAW;
          ld = 1'b1;
        end
      default: state_d = S_PWR;
    endcase
  end

  always_comb begin
    idx_d = (state_d != state_q) ? 7'd0 : idx_q + 7'd1;
    row_d = (state_q == S_IDLE) ? sel_row : cur_q;
    col_d = CW'(idx_d - 7'd1);
    gk    = 6'(idx_d - 7'd1);
    rb    = 2'(row_d);
  end

  always_comb begin
    nxt_rs = 1'b0;
    nxt_byte = 8'h00;
    unique case (state_d)
      S_INIT:
        unique case (idx_d[1:0])
          2'd0:    nxt_byte = 8'h38;
          2'd1:    nxt_byte = 8'h0C;
          2'd2:    nxt_byte = 8'h06;
          default: nxt_byte = 8'h01;
        endcase
      S_CG:
        if (idx_d == 7'd0) begin
          nxt_byte = 8'h40;
        end else begin
          nxt_rs = 1'b1;
          nxt_byte = {3'b000, glyph_q[gk[5:3]][gk[2:0]]};
        end
      S_DRAW:
        if (idx_d == 7'd0) begin
          unique case (rb)
            2'd0:    nxt_byte = 8'h80;
            2'd1:    nxt_byte = 8'hC0;
            2'd2:    nxt_byte = 8'h94;
            default: nxt_byte = 8'hD4;
          endcase
        end else begin
          nxt_rs = 1'b1;
          nxt_byte = buf_q[row_d][col_d];
        end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ph_q    <= PH_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      cur_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (ld) begin
        ph_q   <= PH_SET;
        cnt_q  <= '0;
        idx_q  <= idx_d;
        data_q <= nxt_byte;
        rs_q   <= nxt_rs;
        cur_q  <= row_d;
      end else begin
        unique case (ph_q)
          PH_OFF:
            cnt_q <= (state_q == S_PWR) ?
                     cnt_q + TW'(1) : '0;
          PH_SET:
            if (cnt_q == SET_LIM) begin
              ph_q  <= PH_PUL;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + TW'(1);
            end
          PH_PUL:
            if (cnt_q == PUL_LIM) begin
              ph_q  <= PH_GAP;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + TW'(1);
            end
          default:
            if (byte_done) begin
              ph_q  <= PH_OFF;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + TW'(1);
            end
        endcase
      end
      if (state_q == S_IDLE && !BUSY) ready_q <= 1'b1;
    end
  end

  // Writes land after the issue-time clears, so no update is lost.
  always_comb begin
    row_dirty_d = row_dirty_q;
    glyph_dirty_d = glyph_dirty_q;
    if (state_q == S_CG && state_d == S_IDLE)
      row_dirty_d = '1;
    if (ld && state_d == S_DRAW && idx_d == 7'd0)
      row_dirty_d[row_d] = 1'b0;
    if (ld && state_d == S_CG && idx_d == 7'd0)
      glyph_dirty_d = '0;
    if (wr_ok) row_dirty_d[wr_r] = 1'b1;
    if (gw_ok) glyph_dirty_d[GLYPH_IDX] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          buf_q[r][c] <= 8'h20;
      for (int g = 0; g < 8; g++)
        for (int r = 0; r < 8; r++)
          glyph_q[g][r] <= '0;
      row_dirty_q   <= '1;
      glyph_dirty_q <= GMASK;
    end else begin
      if (wr_ok) buf_q[wr_r][wr_c] <= WR_CHAR;
      if (gw_ok) glyph_q[GLYPH_IDX][GLYPH_ROW] <= GLYPH_BITS;
      row_dirty_q   <= row_dirty_d;
      glyph_dirty_q <= glyph_dirty_d;
    end
  end

  always_comb begin
    BUSY = !(state_q == S_IDLE && !(|row_dirty_q) &&
             !(|glyph_dirty_q));
    READY     = ready_q;
    TLCD_E    = (ph_q == PH_PUL);
    TLCD_RS   = rs_q;
    TLCD_RW   = 1'b0;
    TLCD_DATA = data_q;
  end

endmodule

// File: tb/tb_tlcd_panel_controller.sv
// tb_tlcd_panel_controller: randomized scoreboard bench; expected
// bus bytes come from a model of the panel text and glyph contents.
module tb_tlcd_panel_controller;

  localparam int ROWS = 2;
  localparam int COLS = 16;
  localparam int NG   = 5;
  localparam int PWRW = 20;
  localparam int SETW = 1;
  localparam int EPW  = 2;
  localparam int CMDW = 3;
  localparam int CLRW = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic wr_en, glyph_we;
  logic [1:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_char;
  logic [2:0] glyph_idx, glyph_row;
  logic [4:0] glyph_bits;
  logic ready, busy, tlcd_e, tlcd_rs, tlcd_rw;
  logic [7:0] tlcd_data;

  int total = 0;
  int bad = 0;

  logic [8:0] exp_q[$];
  logic [7:0] mbuf [ROWS][COLS];
  logic [4:0] mgly [8][8];

  bit         m_pe, m_clr;
  int         m_hi, m_lo;
  logic [8:0] m_cap, m_w;

  always #5 clk = ~clk;

  tlcd_panel_controller #(
    .ROWS(ROWS), .COLS(COLS), .NUM_GLYPHS(NG),
    .PWR_WAIT_CYC(PWRW), .SETUP_CYC(SETW),
    .E_PULSE_CYC(EPW), .CMD_WAIT_CYC(CMDW),
    .CLR_WAIT_CYC(CLRW)
  ) dut (
    .CLK(clk), .RESETN(rst_n),
    .WR_EN(wr_en), .WR_ROW(wr_row),
    .WR_COL(wr_col), .WR_CHAR(wr_char),
    .GLYPH_WE(glyph_we), .GLYPH_IDX(glyph_idx),
    .GLYPH_ROW(glyph_row), .GLYPH_BITS(glyph_bits),
    .READY(ready), .BUSY(busy),
    .TLCD_E(tlcd_e), .TLCD_RS(tlcd_rs),
    .TLCD_RW(tlcd_rw), .TLCD_DATA(tlcd_data)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mbuf[r][c] = 8'h20;
    for (int g = 0; g < 8; g++)
      for (int r = 0; r < 8; r++) mgly[g][r] = '0;
  endtask

  function automatic logic [7:0] base(input int r);
    case (r)
      0:       return 8'h80;
      1:       return 8'hC0;
      2:       return 8'h94;
      default: return 8'hD4;
    endcase
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_cg();
    exp_q.push_back({1'b0, 8'h40});
    for (int g = 0; g < NG; g++)
      for (int r = 0; r < 8; r++)
        exp_q.push_back({1'b1, 3'b000, mgly[g][r]});
  endtask

  task automatic push_row(input int r);
    exp_q.push_back({1'b0, base(r)});
    for (int c = 0; c < COLS; c++)
      exp_q.push_back({1'b1, mbuf[r][c]});
  endtask

  task automatic push_all();
    push_cg();
    for (int r = 0; r < ROWS; r++) push_row(r);
  endtask

  task automatic apply(input bit we, input int r, input int c,
                       input logic [7:0] ch, input bit ge,
                       input int gi, input int gr,
                       input logic [4:0] gb);
    bit cv, gv;
    @(negedge clk);
    wr_en = we;
    wr_row = 2'(r);
    wr_col = 5'(c);
    wr_char = ch;
    glyph_we = ge;
    glyph_idx = 3'(gi);
    glyph_row = 3'(gr);
    glyph_bits = gb;
    @(negedge clk);
    wr_en = 1'b0;
    glyph_we = 1'b0;
    cv = we && r < ROWS && c < COLS;
    gv = ge && gi < NG;
    if (cv) mbuf[r][c] = ch;
    if (gv) mgly[gi][gr] = gb;
    if (gv) push_all();
    else if (cv) push_row(r);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " idle"}, busy, 0);
    repeat (2) @(negedge clk);
    chk({nm, " drain"}, exp_q.size(), 0);
    chk({nm, " ready"}, ready, 1);
    exp_q.delete();
  endtask

  task automatic check_quiet(input string nm);
    bit seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || tlcd_e) seen = 1;
    end
    chk(nm, seen, 0);
  endtask

  // Bus monitor: pops one expectation per E rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pe = 0;
        m_hi = 0;
        m_lo = 100000;
        m_clr = 0;
      end else begin
        if (tlcd_e && !m_pe) begin
          total++;
          if (m_lo < (m_clr ? CLRW : CMDW) + SETW) begin
            bad++;
            $display("FAIL gap: low %0d cycles, need %0d",
                     m_lo, (m_clr ? CLRW : CMDW) + SETW);
          end
          m_cap = {tlcd_rs, tlcd_data};
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra byte: got %h want none", m_cap);
          end else begin
            m_w = exp_q.pop_front();
            chk("bus byte", m_cap, m_w);
          end
          m_hi = 1;
        end else if (tlcd_e) begin
          m_hi++;
        end else if (m_pe) begin
          chk("e width", m_hi, EPW);
          chk("hold", {tlcd_rs, tlcd_data}, m_cap);
          m_clr = (m_cap == 9'h001);
          m_lo = 1;
        end else begin
          m_lo++;
        end
        m_pe = tlcd_e;
      end
    end
  end

  initial begin
    int op, r, c, gi, gr, n;
    logic [7:0] ch;
    logic [4:0] gb;
    rst_n = 1'b0;
    wr_en = 0; wr_row = 0; wr_col = 0; wr_char = 0;
    glyph_we = 0; glyph_idx = 0; glyph_row = 0;
    glyph_bits = 0;
    repeat (3) @(negedge clk);
    chk("rst e", tlcd_e, 0);
    chk("rst rs", tlcd_rs, 0);
    chk("rst rw", tlcd_rw, 0);
    chk("rst data", tlcd_data, 0);
    chk("rst ready", ready, 0);
    chk("rst busy", busy, 1);
    model_reset();
    push_init();
    push_all();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("early ready", ready, 0);
    wait_idle("init");

    apply(1, 1, 3, 8'h41, 0, 0, 0, 0);
    wait_idle("row1");

    apply(1, 0, 0, 8'h78, 0, 0, 0, 0);
    n = 0;
    while (exp_q.size() > 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid draw", exp_q.size() <= 10, 1);
    apply(1, 0, 5, 8'h5A, 0, 0, 0, 0);
    wait_idle("redraw");

    apply(0, 0, 0, 8'h00, 1, 2, 7, 5'h1F);
    wait_idle("glyph");

    apply(1, 2, 0, 8'h55, 0, 0, 0, 0);
    check_quiet("bad row");
    apply(0, 0, 0, 8'h00, 1, 6, 1, 5'h0A);
    check_quiet("bad glyph");

    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 5);
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      gi = $urandom_range(0, NG - 1);
      gr = $urandom_range(0, 7);
      ch = 8'($urandom);
      gb = 5'($urandom);
      case (op)
        0, 1: apply(1, r, c, ch, 0, 0, 0, 0);
        2:    apply(0, 0, 0, 0, 1, gi, gr, gb);
        3:    apply(1, r, c, ch, 1, gi, gr, gb);
        4: begin
          if ($urandom_range(0, 1) == 1)
            r = $urandom_range(ROWS, 3);
          else
            c = $urandom_range(COLS, 31);
          apply(1, r, c, ch, 0, 0, 0, 0);
        end
        default: begin
          gi = $urandom_range(NG, 7);
          apply(0, 0, 0, 0, 1, gi, gr, gb);
        end
      endcase
      if (op >= 4) check_quiet("rand quiet");
      else wait_idle("rand");
    end

    apply(1, 0, 1, 8'h33, 0, 0, 0, 0);
    n = 0;
    while (!tlcd_e && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("e seen", tlcd_e, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst e", tlcd_e, 0);
    chk("mid rst data", tlcd_data, 0);
    chk("mid rst ready", ready, 0);
    chk("mid rst busy", busy, 1);
    exp_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    push_init();
    push_all();
    rst_n = 1'b1;
    wait_idle("reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
